// File: rtl/plab4_net_switch_alloc.sv
// Switch allocator and credit controller for the 3-port ring router: route compute,
// round-robin arbitration per output, and ring credit tracking. Optional feature
// macro: PLAB4_NET_SWITCH_ALLOC_BUBBLE_EN (injection needs two credits on ring outputs).
module plab4_net_switch_alloc #(
    parameter int p_srcdest_nbits = 3,
    parameter int p_router_id     = 0,
    parameter int p_num_routers   = 8,
    parameter int p_num_credits   = 2
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       in0_val,
    input  logic [p_srcdest_nbits-1:0] in0_dest,
    output logic                       in0_go,
    input  logic                       in1_val,
    input  logic [p_srcdest_nbits-1:0] in1_dest,
    output logic                       in1_go,
    input  logic                       in2_val,
    input  logic [p_srcdest_nbits-1:0] in2_dest,
    output logic                       in2_go,

    input  logic                       out1_rdy,
    input  logic                       credit_ret_prev,
    input  logic                       credit_ret_next,

    output logic                       out0_val,
    output logic [1:0]                 out0_sel,
    output logic                       out1_val,
    output logic [1:0]                 out1_sel,
    output logic                       out2_val,
    output logic [1:0]                 out2_sel,

    output logic [2:0]                 credits_prev,
    output logic [2:0]                 credits_next,
    output logic                       credit_err
);

    typedef enum logic [1:0] {
        PORT_PREV = 2'd0,
        PORT_TERM = 2'd1,
        PORT_NEXT = 2'd2
    } port_e;

    typedef struct packed {
        logic [2:0] cnt;
        logic       ovf;
    } credit_upd_t;

    localparam logic [2:0] CRED_MAX = 3'(p_num_credits);
    localparam logic [2:0] THRU_MIN = 3'd1;
`ifdef PLAB4_NET_SWITCH_ALLOC_BUBBLE_EN
    // Injection leaves one slot free downstream so the ring can always drain.
    localparam logic [2:0] INJ_MIN  = 3'd2;
`else
    localparam logic [2:0] INJ_MIN  = 3'd1;
`endif

    function automatic port_e route(input logic [p_srcdest_nbits-1:0] dest);
        int fwd;
        fwd = (int'(dest) + p_num_routers - p_router_id) % p_num_routers;
        if (fwd == 0)
            return PORT_TERM;
        if (fwd <= p_num_routers / 2)
            return PORT_NEXT;
        return PORT_PREV;
    endfunction

    function automatic logic [2:0] min_credits(input int in_idx);
        return (in_idx == 1) ? INJ_MIN : THRU_MIN;
    endfunction

    function automatic logic [1:0] add_mod3(input logic [1:0] base, input int offs);
        logic [2:0] sum;
        sum = {1'b0, base} + 3'(offs);
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    function automatic credit_upd_t credit_update(input logic [2:0] cnt,
                                                  input logic       gnt,
                                                  input logic       ret);
        credit_upd_t upd;
        upd.cnt = cnt;
        upd.ovf = 1'b0;
        if (gnt && !ret)
            upd.cnt = cnt - 3'd1;
        else if (!gnt && ret) begin
            if (cnt == CRED_MAX)
                upd.ovf = 1'b1;
            else
                upd.cnt = cnt + 3'd1;
        end
        return upd;
    endfunction

    logic [2:0]                       val_w;
    logic [2:0][p_srcdest_nbits-1:0]  dest_w;
    port_e                            route_w [3];
    logic [2:0][2:0]                  req_w;   // [output][input]
    logic [2:0][2:0]                  gnt_w;   // [output][input]
    logic [2:0][1:0]                  win_w;
    logic [2:0]                       oval_w;

    logic [2:0][1:0]                  ptr_q, ptr_d;
    logic [2:0]                       cred_prev_q, cred_prev_d;
    logic [2:0]                       cred_next_q, cred_next_d;
    logic                             err_q, err_d;
    credit_upd_t                      upd_prev, upd_next;

    assign val_w  = {in2_val, in1_val, in0_val};
    assign dest_w = {in2_dest, in1_dest, in0_dest};

    // Requests are gated by reset so nothing is granted while it is held.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        req_w = '0;
        for (int i = 0; i < 3; i++) begin
            route_w[i] = route(dest_w[i]);
            if (reset && val_w[i]) begin
                case (route_w[i])
                    PORT_TERM: req_w[1][i] = out1_rdy;
                    PORT_PREV: req_w[0][i] = (cred_prev_q >= min_credits(i));
                    PORT_NEXT: req_w[2][i] = (cred_next_q >= min_credits(i));
                    default:   ;
                endcase
            end
        end
    end

    always_comb begin
        logic [1:0] cand;
        cand   = '0;
        gnt_w  = '0;
        win_w  = '0;
        oval_w = '0;
        for (int o = 0; o < 3; o++) begin
            for (int k = 0; k < 3; k++) begin
                cand = add_mod3(ptr_q[o], k);
                if (!oval_w[o] && req_w[o][cand]) begin
                    oval_w[o]      = 1'b1;
                    win_w[o]       = cand;
                    gnt_w[o][cand] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        for (int o = 0; o < 3; o++) begin
            if (oval_w[o])
                ptr_d[o] = add_mod3(win_w[o], 1);
        end
    end

    assign upd_prev    = credit_update(cred_prev_q, oval_w[0], credit_ret_prev);
    assign upd_next    = credit_update(cred_next_q, oval_w[2], credit_ret_next);
    assign cred_prev_d = upd_prev.cnt;
    assign cred_next_d = upd_next.cnt;
    assign err_d       = err_q | upd_prev.ovf | upd_next.ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            cred_prev_q <= CRED_MAX;
            cred_next_q <= CRED_MAX;
            err_q       <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            ptr_q       <= ptr_d;
            cred_prev_q <= cred_prev_d;
            cred_next_q <= cred_next_d;
            err_q       <= err_d;
        end
    end

    assign in0_go = gnt_w[0][0] | gnt_w[1][0] | gnt_w[2][0];
    assign in1_go = gnt_w[0][1] | gnt_w[1][1] | gnt_w[2][1];
    assign in2_go = gnt_w[0][2] | gnt_w[1][2] | gnt_w[2][2];

    assign out0_val = oval_w[0];
    assign out1_val = oval_w[1];
    assign out2_val = oval_w[2];
    assign out0_sel = win_w[0];
    assign out1_sel = win_w[1];
    assign out2_sel = win_w[2];

    assign credits_prev = cred_prev_q;
    assign credits_next = cred_next_q;
    assign credit_err   = err_q;

endmodule

// File: tb/tb_plab4_net_switch_alloc.sv
// Self-checking bench for plab4_net_switch_alloc: spec-level model compared every cycle,
// plus directed vectors with literal expectations (router 2 of 8, two credits).
module tb_plab4_net_switch_alloc;

    localparam int ID = 2;
    localparam int NR = 8;
    localparam int NC = 2;
`ifdef PLAB4_NET_SWITCH_ALLOC_BUBBLE_EN
    localparam int INJ_NEED = 2;
`else
    localparam int INJ_NEED = 1;
`endif

    typedef struct packed {
        logic [2:0]      go;
        logic [2:0]      val;
        logic [2:0][1:0] sel;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [2:0]      val;
    logic [2:0]      dst [3];
    logic            out1_rdy, ret_prev, ret_next;
    logic [2:0]      go;
    logic [2:0]      oval;
    logic [2:0][1:0] osel;
    logic [2:0]      cr_prev, cr_next;
    logic            cerr;

    int n_checks = 0;
    int n_fail   = 0;

    int m_ptr  [3];
    int m_cred [2];   // [0] = prev ring output, [1] = next ring output
    bit m_err;

    plab4_net_switch_alloc #(
        .p_srcdest_nbits(3),
        .p_router_id    (ID),
        .p_num_routers  (NR),
        .p_num_credits  (NC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in0_val        (val[0]),
        .in0_dest       (dst[0]),
        .in0_go         (go[0]),
        .in1_val        (val[1]),
        .in1_dest       (dst[1]),
        .in1_go         (go[1]),
        .in2_val        (val[2]),
        .in2_dest       (dst[2]),
        .in2_go         (go[2]),
        .out1_rdy       (out1_rdy),
        .credit_ret_prev(ret_prev),
        .credit_ret_next(ret_next),
        .out0_val       (oval[0]),
        .out0_sel       (osel[0]),
        .out1_val       (oval[1]),
        .out1_sel       (osel[1]),
        .out2_val       (oval[2]),
        .out2_sel       (osel[2]),
        .credits_prev   (cr_prev),
        .credits_next   (cr_next),
        .credit_err     (cerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Output index for a destination: 1 = terminal, 2 = next, 0 = prev.
    function automatic int route(input int dest);
        int fwd;
        fwd = ((dest - ID) % NR + NR) % NR;
        if (fwd == 0)       return 1;
        if (fwd * 2 <= NR)  return 2;
        return 0;
    endfunction

    function automatic bit eligible(input int inp, input int outp);
        int need;
        need = (inp == 1) ? INJ_NEED : 1;
        if (outp == 1) return out1_rdy;
        if (outp == 0) return m_cred[0] >= need;
        return m_cred[1] >= need;
    endfunction

    function automatic exp_t model_eval();
        exp_t e;
        bit   found;
        int   inp;
        e = '0;
        if (reset !== 1'b1) return e;
        for (int o = 0; o < 3; o++) begin
            found = 0;
            for (int k = 0; k < 3; k++) begin
                inp = (m_ptr[o] + k) % 3;
                if (!found && val[inp] && route(int'(dst[inp])) == o && eligible(inp, o)) begin
                    found      = 1;
                    e.go[inp]  = 1'b1;
                    e.val[o]   = 1'b1;
                    e.sel[o]   = 2'(inp);
                end
            end
        end
        return e;
    endfunction

    always @(posedge clk or negedge reset) begin
        exp_t e;
        if (!reset) begin
            m_ptr  <= '{0, 0, 0};
            m_cred <= '{NC, NC};
            m_err  <= 1'b0;
        end else begin
            e = model_eval();
            for (int o = 0; o < 3; o++)
                if (e.val[o]) m_ptr[o] <= (int'(e.sel[o]) + 1) % 3;
            if (e.val[0] && !ret_prev)      m_cred[0] <= m_cred[0] - 1;
            else if (!e.val[0] && ret_prev) begin
                if (m_cred[0] == NC) m_err <= 1'b1;
                else                 m_cred[0] <= m_cred[0] + 1;
            end
            if (e.val[2] && !ret_next)      m_cred[1] <= m_cred[1] - 1;
            else if (!e.val[2] && ret_next) begin
                if (m_cred[1] == NC) m_err <= 1'b1;
                else                 m_cred[1] <= m_cred[1] + 1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = model_eval();
        check("model_go",   32'(go),      32'(e.go));
        check("model_val",  32'(oval),    32'(e.val));
        check("model_sel",  32'(osel),    32'(e.sel));
        check("model_crp",  32'(cr_prev), 32'(m_cred[0]));
        check("model_crn",  32'(cr_next), 32'(m_cred[1]));
        check("model_err",  32'(cerr),    32'(m_err));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        int       rr_seq  [6];
        int       rr2_seq [4];
        int       rt_dest [5];
        logic [2:0] rt_oval [5];
        rr_seq  = '{0, 1, 2, 0, 1, 2};
        rr2_seq = '{0, 2, 0, 2};
        rt_dest = '{2, 3, 6, 7, 0};
        rt_oval = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b001};

        reset    = 1'b0;
        val      = '0;
        dst      = '{3'd0, 3'd0, 3'd0};
        out1_rdy = 1'b1;
        ret_prev = 1'b0;
        ret_next = 1'b0;
        step();
        step();

        // Reset holds everything idle even with all inputs valid.
        val = 3'b111;
        dst = '{3'd2, 3'd2, 3'd2};
        #2;
        check("rst_go",  32'(go),      32'd0);
        check("rst_val", 32'(oval),    32'd0);
        check("rst_crp", 32'(cr_prev), 32'd2);
        check("rst_crn", 32'(cr_next), 32'd2);
        check("rst_err", 32'(cerr),    32'd0);
        reset = 1'b1;
        #1;
        check("rel_val", 32'(oval[1]), 32'd1);
        check("rr_sel0", 32'(osel[1]), 32'(rr_seq[0]));
        check("rel_go",  32'(go),      32'b001);
        for (int c = 1; c < 6; c++) begin
            step();
            #2;
            check("rr_sel", 32'(osel[1]), 32'(rr_seq[c]));
        end

        // Asynchronous reset drops an in-flight grant at once.
        step();
        #2;
        reset = 1'b0;
        #1;
        check("async_go",  32'(go),   32'd0);
        check("async_val", 32'(oval), 32'd0);
        step();
        val   = 3'b101;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            check("rr2_sel", 32'(osel[1]), 32'(rr2_seq[c]));
            check("rr2_go1", 32'(go[1]),   32'd0);
            step();
        end

        // Routing from router 2 of 8.
        val = '0;
        do_reset();
        val = 3'b001;
        for (int c = 0; c < 5; c++) begin
            dst[0] = 3'(rt_dest[c]);
            #2;
            check("route_val", 32'(oval), 32'(rt_oval[c]));
            check("route_go",  32'(go),   32'b001);
            step();
        end
        out1_rdy = 1'b0;
        dst[0]   = 3'd2;
        #2;
        check("route_blk_go", 32'(go),      32'd0);
        check("route_crn",    32'(cr_next), 32'd0);
        check("route_crp",    32'(cr_prev), 32'd0);
        step();

        // Credit exhaustion, return and simultaneous grant/return.
        val      = '0;
        out1_rdy = 1'b1;
        do_reset();
        val    = 3'b001;
        dst[0] = 3'd3;
        #2;
        check("cx_go1",  32'(go),      32'b001);
        check("cx_cr1",  32'(cr_next), 32'd2);
        step();
        #2;
        check("cx_go2",  32'(go),      32'b001);
        check("cx_cr2",  32'(cr_next), 32'd1);
        step();
        #2;
        check("cx_go3",  32'(go),      32'd0);
        check("cx_cr3",  32'(cr_next), 32'd0);
        ret_next = 1'b1;
        step();
        ret_next = 1'b0;
        #2;
        check("cx_go4",  32'(go),      32'b001);
        check("cx_cr4",  32'(cr_next), 32'd1);
        ret_next = 1'b1;
        step();
        ret_next = 1'b0;
        #2;
        check("cx_cr5",  32'(cr_next), 32'd1);
        check("cx_go5",  32'(go),      32'b001);
        step();
        #2;
        check("cx_cr6",  32'(cr_next), 32'd0);
        check("cx_go6",  32'(go),      32'd0);

        // Injection versus through traffic with one credit left.
        val = '0;
        do_reset();
        val    = 3'b001;
        dst[0] = 3'd3;
        #2;
        check("bub_drain", 32'(go), 32'b001);
        step();
        val    = 3'b011;
        dst[1] = 3'd3;
        #2;
        check("bub_crn", 32'(cr_next), 32'd1);
`ifdef PLAB4_NET_SWITCH_ALLOC_BUBBLE_EN
        check("bub_go",  32'(go),      32'b001);
        check("bub_sel", 32'(osel[2]), 32'd0);
`else
        check("bub_go",  32'(go),      32'b010);
        check("bub_sel", 32'(osel[2]), 32'd1);
`endif
        step();

        // Credit returned with the counter full raises a sticky error.
        val = '0;
        do_reset();
        ret_prev = 1'b1;
        #2;
        check("cerr_pre", 32'(cerr), 32'd0);
        step();
        ret_prev = 1'b0;
        #2;
        check("cerr_crp", 32'(cr_prev), 32'd2);
        check("cerr_set", 32'(cerr),    32'd1);
        step();
        step();
        #2;
        check("cerr_hold", 32'(cerr), 32'd1);
        step();
        do_reset();
        #2;
        check("cerr_clr", 32'(cerr), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
